router_dst_port: RTL and testbench

Parametrised destination-side output port of the 1xN router: one per destination channel, between the router core's write path and the external destination interface (`data_out` / `read_enb` / `valid_out`). It buffers packet words in a DEPTH-entry FIFO tagged with a header flag, and tracks packet boundaries to flag the last word of each packet. Optionally, it flushes itself when the destination leaves valid data unread for TIMEOUT cycles.

---
 rtl/router_dst_port.sv | 177 +++++++++++++++++
 tb/tb_router_dst_port.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_dst_port.sv
// Destination output port of the 1xN router: header-tagged word FIFO with packet-end tracking.
// Latency: write visible on valid_out one edge later; read data registered, one cycle after read_enb.
// Backpressure: writes dropped while full; with ROUTER_DST_TIMEOUT_EN, TIMEOUT idle-valid cycles flush the FIFO.
//
// ROUTER_DST_TIMEOUT_EN: when defined, compiles in the unread-data timeout counter and
// the soft_reset flush. When undefined, soft_reset is tied low and data is held until read.
module router_dst_port #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int LEN_LSB = 2,
    parameter int TIMEOUT = 30
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             write_enb,
    input  logic             lfd_state,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data_out,
    output logic             eop,
    input  logic             read_enb,
    output logic             valid_out,
    output logic             soft_reset
);

    // Address bits plus one wrap bit so full and empty can be told apart.
    localparam int AW = $clog2(DEPTH);
    // One bit wider than the header length field so length+1 never overflows.
    localparam int CW = WIDTH - LEN_LSB + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("router_dst_port: DEPTH must be a power of two and at least 4");
    end

    if (LEN_LSB < 1 || LEN_LSB >= WIDTH) begin : g_bad_len_lsb
        $error("router_dst_port: LEN_LSB must lie inside the data word");
    end

    // Storage: bit WIDTH marks a header word, bits WIDTH-1:0 carry the data.
    logic [WIDTH:0]   mem_q [DEPTH];

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             eop_q, eop_d;

    logic             wr_fire;
    logic             rd_fire;
    logic             flush;
    logic [WIDTH:0]   rd_word;
    logic [CW-1:0]    hdr_len;

    // Status comes from registered pointers only, so no input reaches these outputs.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign valid_out = !empty;

    // Full is judged on the current occupancy, so a read in the same cycle cannot make room.
    // A flush wins over a write presented on the same edge.
    assign wr_fire = write_enb && !full && !flush;
    assign rd_fire = read_enb && !empty;

    assign rd_word = mem_q[rd_ptr_q[AW-1:0]];
    // Header length field widened by one bit; the stored count covers payload plus parity.
    assign hdr_len = {1'b0, rd_word[WIDTH-1:LEN_LSB]};

    assign data_out = data_out_q;
    assign eop      = eop_q;

`ifdef ROUTER_DST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("router_dst_port: TIMEOUT must be at least 2");
    end

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          soft_reset_q, soft_reset_d;
    logic          idle_valid;

    // A cycle counts toward the timeout when data is waiting and the destination is not reading.
    assign idle_valid = valid_out && !read_enb;
    // Fire on the edge that closes the TIMEOUT-th consecutive idle-valid cycle.
    assign flush      = idle_valid && (to_cnt_q == TW'(TIMEOUT - 1));
    assign soft_reset = soft_reset_q;

    // Timeout counter next state: count idle-valid run, restart on any break or on flush.
    always_comb begin
        to_cnt_d     = '0;
        soft_reset_d = flush;
        if (idle_valid && !flush) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    // Timeout counter and one-cycle soft_reset pulse registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            to_cnt_q     <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            to_cnt_q     <= to_cnt_d;
            soft_reset_q <= soft_reset_d;
        end
    end
`else
    assign flush      = 1'b0;
    assign soft_reset = 1'b0;
`endif

    // FIFO storage write; contents are deliberately left untouched by reset.
    always_ff @(posedge clock) begin
        if (resetn && wr_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    // Next-state for pointers, packet counter and registered read outputs.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;
        eop_d      = eop_q;

        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
        end

        if (rd_fire) begin
            rd_ptr_d   = rd_ptr_q + (AW + 1)'(1);
            data_out_d = rd_word[WIDTH-1:0];
            if (rd_word[WIDTH]) begin
                // New packet: expect payload words followed by one parity word.
                pkt_cnt_d = hdr_len + CW'(1);
                eop_d     = 1'b0;
            end else begin
                // The word that brings the count from 1 to 0 is the packet's last.
                // An orphan word (count already 0) passes through without eop.
                eop_d = (pkt_cnt_q == CW'(1));
                if (pkt_cnt_q != '0) begin
                    pkt_cnt_d = pkt_cnt_q - CW'(1);
                end
            end
        end

        // Timeout flush discards everything buffered and clears the read side.
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pkt_cnt_d  = '0;
            data_out_d = '0;
            eop_d      = 1'b0;
        end
    end

    // Pointer, packet counter and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
            eop_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
            eop_q      <= eop_d;
        end
    end

endmodule

// File: tb/tb_router_dst_port.sv
// Scoreboard bench for router_dst_port: directed packets, fill/drain, wrap, mid-packet reset, timeout.
// Expected read words are queued at write time; a monitor compares each registered read result.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there or on the falling edge.
module tb_router_dst_port;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 16;
    localparam int LEN_LSB = 2;
    localparam int TIMEOUT = 30;

    logic             clock = 1'b0;
    logic             resetn;
    logic [WIDTH-1:0] data_in;
    logic             write_enb;
    logic             lfd_state;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] data_out;
    logic             eop;
    logic             read_enb;
    logic             valid_out;
    logic             soft_reset;

    int checks = 0;
    int errors = 0;

    // Each entry: {expected eop, expected data}.
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] mon_e;
    logic           fire_q = 1'b0;

    router_dst_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .LEN_LSB(LEN_LSB),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .data_in   (data_in),
        .write_enb (write_enb),
        .lfd_state (lfd_state),
        .full      (full),
        .empty     (empty),
        .data_out  (data_out),
        .eop       (eop),
        .read_enb  (read_enb),
        .valid_out (valid_out),
        .soft_reset(soft_reset)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One clock cycle with the given inputs, then inputs return to idle.
    task automatic cycle(input logic we, input logic [WIDTH-1:0] d, input logic lfd, input logic re);
        write_enb = we;
        data_in   = d;
        lfd_state = lfd;
        read_enb  = re;
        tick();
        write_enb = 1'b0;
        data_in   = '0;
        lfd_state = 1'b0;
        read_enb  = 1'b0;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic e);
        exp_q.push_back({e, d});
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_eop"}, eop, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_valid_out"}, valid_out, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_soft_reset"}, soft_reset, 0);
    endtask

    // A read accepted at this edge produces data_out/eop after it.
    always @(posedge clock) begin
        fire_q <= resetn && read_enb && valid_out;
    end

    // Monitor: compare the registered read result against the oldest expected word.
    always @(negedge clock) begin
        if (fire_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: read data 0x%0h with no expected word (t=%0t)", data_out, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_data_out", data_out, mon_e[WIDTH-1:0]);
                chk("sb_eop", eop, mon_e[WIDTH]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn    = 1'b0;
        data_in   = '0;
        write_enb = 1'b0;
        lfd_state = 1'b0;
        read_enb  = 1'b0;
        tick();
        tick();
        chk_reset_state("rst");
        resetn = 1'b1;

        // Packet: header 0x0D (len 3, addr 1), three payload words, parity 0x55.
        cycle(1'b1, 8'h0D, 1'b1, 1'b0); push(8'h0D, 1'b0);
        chk("wr_valid_out", valid_out, 1);
        cycle(1'b1, 8'hA1, 1'b0, 1'b0); push(8'hA1, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0, 1'b0); push(8'hA2, 1'b0);
        cycle(1'b1, 8'hA3, 1'b0, 1'b0); push(8'hA3, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b0); push(8'h55, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("pkt_empty", empty, 1);

        // Fill all 16 entries with orphan words.
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_not_full", full, 0);
            cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0); push(8'h10 + 8'(i), 1'b0);
        end
        chk("fill_full", full, 1);
        chk("fill_valid_out", valid_out, 1);
        // Write while full with a concurrent read: write must be dropped.
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("drop_full_cleared", full, 0);
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("drain_empty", empty, 1);
        chk("drain_full", full, 0);

        // Occupancy 8, then 20 simultaneous read+write cycles across pointer wrap.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0); push(8'h20 + 8'(i), 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'h28 + 8'(i), 1'b0, 1'b1); push(8'h28 + 8'(i), 1'b0);
            chk("rw_not_full", full, 0);
            chk("rw_not_empty", empty, 0);
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("rw_drained_empty", empty, 1);

        // Reset mid-packet after header and one payload word have been read.
        cycle(1'b1, 8'h0D, 1'b1, 1'b0); push(8'h0D, 1'b0);
        cycle(1'b1, 8'hA1, 1'b0, 1'b0); push(8'hA1, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0, 1'b0); push(8'hA2, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        resetn = 1'b0;
        tick();
        exp_q.delete();
        chk_reset_state("midrst");
        resetn = 1'b1;
        // Header 0x04: length 1, so eop comes with the second post-header word.
        cycle(1'b1, 8'h04, 1'b1, 1'b0); push(8'h04, 1'b0);
        cycle(1'b1, 8'hB1, 1'b0, 1'b0); push(8'hB1, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0, 1'b0); push(8'hB2, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("post_rst_empty", empty, 1);

`ifdef ROUTER_DST_TIMEOUT_EN
        // One word left unread: flush at the edge ending the 30th valid cycle.
        cycle(1'b1, 8'h61, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            chk("to_no_pulse_yet", soft_reset, 0);
            chk("to_still_valid", valid_out, 1);
        end
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("to_pulse", soft_reset, 1);
        chk("to_valid_cleared", valid_out, 0);
        chk("to_data_cleared", data_out, 0);
        chk("to_eop_cleared", eop, 0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("to_pulse_drop", soft_reset, 0);

        // Read during the 29th cycle: counter restarts, no flush.
        cycle(1'b1, 8'h62, 1'b0, 1'b0); push(8'h62, 1'b0);
        for (int i = 0; i < TIMEOUT - 2; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < TIMEOUT + 5; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            chk("to_read_no_pulse", soft_reset, 0);
        end
        chk("to_read_empty", empty, 1);

        // Write presented on the flush edge is lost.
        cycle(1'b1, 8'h63, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 8'h64, 1'b0, 1'b0);
        chk("to_wr_pulse", soft_reset, 1);
        chk("to_wr_dropped_empty", empty, 1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("to_wr_still_empty", empty, 1);
        chk("to_wr_pulse_drop", soft_reset, 0);
`else
        // Without the timeout, an unread word is held indefinitely.
        cycle(1'b1, 8'h77, 1'b0, 1'b0); push(8'h77, 1'b0);
        for (int i = 0; i < TIMEOUT + 10; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            chk("hold_no_soft_reset", soft_reset, 0);
        end
        chk("hold_valid_out", valid_out, 1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("hold_empty", empty, 1);
`endif

        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
